// File: rtl/tl_pkg.sv
// Shared TileLink A-channel types: the beat record held by the repeater and the A opcode encodings.
package tl_pkg;

   localparam int TL_ADDR_W = 26;
   localparam int TL_SRC_W  = 7;
   localparam int TL_SIZE_W = 3;
   localparam int TL_DATA_W = 32;
   localparam int TL_MASK_W = TL_DATA_W / 8;

   localparam logic [2:0] A_PUT_FULL    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] A_ARITH       = 3'd2;
   localparam logic [2:0] A_LOGIC       = 3'd3;
   localparam logic [2:0] A_GET         = 3'd4;
   localparam logic [2:0] A_HINT        = 3'd5;

   typedef struct packed {
      logic [2:0]           opcode;
      logic [2:0]           param;
      logic [TL_SIZE_W-1:0] size;
      logic [TL_SRC_W-1:0]  source;
      logic [TL_ADDR_W-1:0] address;
      logic [TL_MASK_W-1:0] mask;
      logic [TL_DATA_W-1:0] data;
      logic                 corrupt;
   } tl_a_beat_t;

   typedef enum logic {
      A_EMPTY = 1'b0,
      A_HOLD  = 1'b1
   } a_rep_state_t;

endpackage

// File: rtl/tl_a_repeater.sv
// TileLink A-channel repeater: passes beats straight through, or captures one beat and
// replays it for as long as repeat_i is held on each downstream handshake.
module tl_a_repeater
   import tl_pkg::*;
#(
   parameter int ADDR_W = TL_ADDR_W,
   parameter int SRC_W  = TL_SRC_W,
   parameter int SIZE_W = TL_SIZE_W,
   parameter int DATA_W = TL_DATA_W,
   localparam int MASK_W = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              repeat_i,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [2:0]        enq_opcode,
   input  logic [2:0]        enq_param,
   input  logic [SIZE_W-1:0] enq_size,
   input  logic [SRC_W-1:0]  enq_source,
   input  logic [ADDR_W-1:0] enq_address,
   input  logic [MASK_W-1:0] enq_mask,
   input  logic [DATA_W-1:0] enq_data,
   input  logic              enq_corrupt,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [2:0]        deq_opcode,
   output logic [2:0]        deq_param,
   output logic [SIZE_W-1:0] deq_size,
   output logic [SRC_W-1:0]  deq_source,
   output logic [ADDR_W-1:0] deq_address,
   output logic [MASK_W-1:0] deq_mask,
   output logic [DATA_W-1:0] deq_data,
   output logic              deq_corrupt,
   output logic              full_o,
   output logic [MASK_W-1:0] saved_mask_o
);

   a_rep_state_t state_reg, state_next;
   tl_a_beat_t   saved_reg;
   tl_a_beat_t   enq_beat;
   tl_a_beat_t   deq_beat;
   logic         full;
   logic         load_saved;

   assign enq_beat = '{
      opcode:  enq_opcode,
      param:   enq_param,
      size:    enq_size,
      source:  enq_source,
      address: enq_address,
      mask:    enq_mask,
      data:    enq_data,
      corrupt: enq_corrupt
   };

   assign full      = (state_reg == A_HOLD);
   assign deq_valid = enq_valid | full;
   assign enq_ready = deq_ready & ~full;
   assign deq_beat  = full ? saved_reg : enq_beat;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= A_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Entry captures the beat on the same edge it first leaves; exit happens on the last replay.
   always_comb begin
      state_next = state_reg;
      load_saved = 1'b0;
      case (state_reg)
         A_EMPTY: begin
            if (enq_valid && enq_ready && repeat_i) begin
               state_next = A_HOLD;
               load_saved = 1'b1;
            end
         end
         A_HOLD: begin
            if (deq_valid && deq_ready && !repeat_i) begin
               state_next = A_EMPTY;
            end
         end
         default: state_next = A_EMPTY;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         saved_reg <= '0;
      end else if (load_saved) begin
         saved_reg <= enq_beat;
      end
   end

   assign deq_opcode   = deq_beat.opcode;
   assign deq_param    = deq_beat.param;
   assign deq_size     = deq_beat.size;
   assign deq_source   = deq_beat.source;
   assign deq_address  = deq_beat.address;
   assign deq_mask     = deq_beat.mask;
   assign deq_data     = deq_beat.data;
   assign deq_corrupt  = deq_beat.corrupt;
   assign full_o       = full;
   assign saved_mask_o = saved_reg.mask;

endmodule
